// File: rtl/p2b_multi_window.sv
// Multi-channel stochastic bitstream to binary converter.
// Counts ones per channel over a WIN_LEN-sample window and publishes all channels together.
module p2b_multi_window #(
  parameter int NUM_CH  = 4,
  parameter int BIN_LEN = 8,
  parameter int WIN_LEN = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            sync_clr,
  input  logic                            bipolar,
  input  logic [NUM_CH-1:0]               in_bits,
  output logic [NUM_CH*(BIN_LEN+1)-1:0]   out_val,
  output logic                            out_valid,
  output logic                            out_mode
);

  localparam int OUT_W = BIN_LEN + 1;
  localparam logic [BIN_LEN-1:0] LAST_IDX = BIN_LEN'(WIN_LEN - 1);
  localparam logic [OUT_W-1:0]   WIN_W    = OUT_W'(WIN_LEN);

  logic [BIN_LEN-1:0] win_cnt;
  logic [BIN_LEN-1:0] acc [NUM_CH];
  logic               mode_q;

  logic               last_sample;
  logic [OUT_W-1:0]   total  [NUM_CH];
  logic [OUT_W-1:0]   result [NUM_CH];

  // total includes the current sample so the closing edge sees exactly WIN_LEN samples
  always_comb begin
    last_sample = (win_cnt == LAST_IDX);
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      total[c]  = {1'b0, acc[c]} + OUT_W'(in_bits[c]);
      result[c] = mode_q ? ({total[c][OUT_W-2:0], 1'b0} - WIN_W) : total[c];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt   <= '0;
      mode_q    <= 1'b0;
      out_val   <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else if (sync_clr) begin
      win_cnt   <= '0;
      mode_q    <= bipolar;
      out_valid <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else if (enable) begin
      if (last_sample) begin
        win_cnt   <= '0;
        mode_q    <= bipolar;
        out_valid <= 1'b1;
        out_mode  <= mode_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          out_val[c*OUT_W +: OUT_W] <= result[c];
          acc[c]                    <= '0;
        end
      end else begin
        win_cnt   <= win_cnt + BIN_LEN'(1);
        out_valid <= 1'b0;
        // acc stays below WIN_LEN here, so the narrow copy never truncates
        for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= total[c][BIN_LEN-1:0];
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p2b_multi_window.sv
// Bench for p2b_multi_window: directed spec scenarios plus random traffic,
// checked against a per-window arithmetic model for WIN_LEN=8 and WIN_LEN=1.
module tb_p2b_multi_window;

  localparam int NC = 4;
  localparam int OW = 9;

  logic clock = 1'b0;
  logic reset, enable, sync_clr, bipolar;
  logic [NC-1:0] in_bits;
  logic [NC*OW-1:0] out_val0, out_val1;
  logic out_valid0, out_valid1, out_mode0, out_mode1;

  always #5 clock = ~clock;

  p2b_multi_window #(.NUM_CH(4), .BIN_LEN(8), .WIN_LEN(8)) u_w8 (
    .clock(clock), .reset(reset), .enable(enable), .sync_clr(sync_clr),
    .bipolar(bipolar), .in_bits(in_bits), .out_val(out_val0),
    .out_valid(out_valid0), .out_mode(out_mode0));

  p2b_multi_window #(.NUM_CH(4), .BIN_LEN(8), .WIN_LEN(1)) u_w1 (
    .clock(clock), .reset(reset), .enable(enable), .sync_clr(sync_clr),
    .bipolar(bipolar), .in_bits(in_bits), .out_val(out_val1),
    .out_valid(out_valid1), .out_mode(out_mode1));

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: [0] WIN_LEN=8, [1] WIN_LEN=1
  int wl [2] = '{8, 1};
  int m_cnt [2];
  int m_sum [2][NC];
  bit m_mq  [2];
  int m_ev  [2][NC];
  bit m_valid [2];
  bit m_mode  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge(input logic r, input logic c, input logic e,
                            input logic b, input logic [NC-1:0] bits);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_cnt[k] = 0; m_mq[k] = 0; m_valid[k] = 0; m_mode[k] = 0;
        for (int ch = 0; ch < NC; ch++) begin m_sum[k][ch] = 0; m_ev[k][ch] = 0; end
      end else if (c) begin
        m_cnt[k] = 0; m_mq[k] = b; m_valid[k] = 0;
        for (int ch = 0; ch < NC; ch++) m_sum[k][ch] = 0;
      end else if (!e) begin
        m_valid[k] = 0;
      end else begin
        m_cnt[k]++;
        for (int ch = 0; ch < NC; ch++) m_sum[k][ch] += int'(bits[ch]);
        if (m_cnt[k] == wl[k]) begin
          for (int ch = 0; ch < NC; ch++) begin
            m_ev[k][ch] = m_mq[k] ? (2 * m_sum[k][ch] - wl[k]) : m_sum[k][ch];
            m_sum[k][ch] = 0;
          end
          m_mode[k] = m_mq[k]; m_valid[k] = 1; m_cnt[k] = 0; m_mq[k] = b;
        end else begin
          m_valid[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [OW-1:0] e9;
    logic [NC*OW-1:0] ov;
    for (int k = 0; k < 2; k++) begin
      ov = (k == 0) ? out_val0 : out_val1;
      chk($sformatf("w%0d_valid", wl[k]), (k == 0) ? out_valid0 : out_valid1, m_valid[k]);
      chk($sformatf("w%0d_mode", wl[k]), (k == 0) ? out_mode0 : out_mode1, m_mode[k]);
      for (int ch = 0; ch < NC; ch++) begin
        e9 = m_ev[k][ch][OW-1:0];
        chk($sformatf("w%0d_val_ch%0d", wl[k], ch), ov[ch*OW +: OW], e9);
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic e,
                      input logic b, input logic [NC-1:0] bits);
    reset = r; sync_clr = c; enable = e; bipolar = b; in_bits = bits;
    @(posedge clock);
    model_edge(r, c, e, b, bits);
    #1;
    compare_all();
  endtask

  function automatic logic [NC-1:0] pattern(input int i);
    logic [NC-1:0] p;
    p[0] = 1'b1;
    p[1] = 1'b0;
    p[2] = (i % 2 == 0);
    p[3] = (i == 7);
    return p;
  endfunction

  logic bip;

  initial begin
    reset = 1'b1; sync_clr = 1'b0; enable = 1'b0; bipolar = 1'b0; in_bits = '0;
    bip = 1'b0;

    // reset state
    step(1, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0);
    chk("reset_val", out_val0, '0);
    chk("reset_valid", out_valid0, 1'b0);

    // scenario 1: unipolar streams
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, pattern(i));
      if (i < 7) chk("t1_no_early_strobe", out_valid0, 1'b0);
    end
    chk("t1_strobe", out_valid0, 1'b1);
    chk("t1_vals", out_val0, {9'd1, 9'd4, 9'd0, 9'd8});
    step(0, 0, 0, 0, 4'h0);
    chk("t1_strobe_one_cycle", out_valid0, 1'b0);

    // scenario 2: bipolar latched by sync_clr, same streams
    step(0, 1, 0, 1, 4'hF);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, pattern(i));
    chk("t2_vals", out_val0, {9'h1FA, 9'h000, 9'h1F8, 9'h008});
    chk("t2_mode", out_mode0, 1'b1);

    // scenario 3: enable gap with all-ones input
    step(0, 1, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, pattern(i));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'hF);
    for (int i = 4; i < 8; i++) step(0, 0, 1, 0, pattern(i));
    chk("t3_strobe", out_valid0, 1'b1);
    chk("t3_ch0", out_val0[8:0], 9'd8);
    chk("t3_ch2", out_val0[26:18], 9'd4);

    // scenario 4: sync_clr after 5 samples
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 4'hF);
    step(0, 1, 1, 0, 4'hF);
    chk("t4_held", out_val0, {9'd1, 9'd4, 9'd0, 9'd8});
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 4'b0101);
    chk("t4_vals", out_val0, {9'd0, 9'd8, 9'd0, 9'd8});

    // scenario 5: toggle bipolar mid-window
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 4'b0011);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 4'b0011);
    chk("t5_old_mode", out_mode0, 1'b0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 4'b0011);
    chk("t5_new_mode", out_mode0, 1'b1);
    chk("t5_vals", out_val0, {9'h1F8, 9'h1F8, 9'h008, 9'h008});

    // scenario 6: back-to-back windows, reset mid-window
    for (int i = 0; i < 24; i++) step(0, 0, 1, 0, 4'($urandom));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'($urandom));
    step(1, 0, 1, 0, 4'hF);
    chk("t6_reset_val", out_val0, '0);
    chk("t6_reset_mode", out_mode0, 1'b0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 4'($urandom));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) bip = ~bip;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) != 0),
           bip, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
